// File: rtl/rvvi_ack_receiver.sv
// rvvi_ack_receiver: receive end of the RVVI trace link.
// Classifies each accepted frame by minstret against the expected sequence number:
// in-order frames are forwarded and ACKed, duplicates are re-ACKed and dropped,
// frames ahead of expected are dropped without an ACK so the sender replays them.
// Optional feature: define RVVI_RX_STATS_EN to add DupCount/GapCount/ResyncCount outputs.
module rvvi_ack_receiver #(
    parameter int unsigned WIDTH    = 792,
    parameter int unsigned ACKWIDTH = 224,
    parameter int unsigned SEQOFF   = 160,
    parameter int unsigned SEQW     = 64,
    parameter int unsigned ACKDEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RxValid,
    input  logic [WIDTH-1:0]    RxData,
    output logic                RxReady,
    output logic                OutValid,
    output logic [WIDTH-1:0]    OutData,
    input  logic                OutReady,
    output logic                AckValid,
    output logic [ACKWIDTH-1:0] AckData,
    input  logic                AckReady,
    output logic [SEQW-1:0]     ExpectedSeq
`ifdef RVVI_RX_STATS_EN
    ,
    output logic [31:0]         DupCount,
    output logic [31:0]         GapCount,
    output logic [31:0]         ResyncCount
`endif
);

    localparam int unsigned AW = $clog2(ACKDEPTH);

    typedef enum logic [0:0] {StRun, StResync} state_e;

    state_e              state_q, state_d;
    logic [SEQW-1:0]     exp_seq_q, exp_seq_d;
    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]         rd_ptr_q, rd_ptr_d;
    // Only the sequence field of an ACK is non-zero, so only that is stored.
    logic [SEQW-1:0]     ack_mem_q [ACKDEPTH];

    logic [SEQW-1:0]     rx_seq;
    logic [SEQW-1:0]     seq_diff;
    logic                is_inorder, is_dup, is_gap;
    logic                rx_fire;
    logic                ack_full, ack_empty, ack_push, ack_pop;
    logic                enter_resync;

    // Frame classification, FIFO status and link handshake.
    always_comb begin
        rx_seq     = RxData[SEQOFF +: SEQW];
        seq_diff   = rx_seq - exp_seq_q;
        is_inorder = (seq_diff == '0);
        is_dup     = ~is_inorder & seq_diff[SEQW-1];
        is_gap     = ~is_inorder & ~seq_diff[SEQW-1];
        ack_empty  = (wr_ptr_q == rd_ptr_q);
        ack_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // Registered full keeps push-while-full impossible even when a pop is pending.
        RxReady    = reset & ~ack_full & (~out_valid_q | OutReady);
        rx_fire    = RxValid & RxReady;
        ack_push   = rx_fire & (is_inorder | is_dup);
        ack_pop    = ~ack_empty & AckReady;
    end

    // Next state of the expected sequence, output register and ACK FIFO pointers.
    always_comb begin
        exp_seq_d   = exp_seq_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (out_valid_q && OutReady) begin
            out_valid_d = 1'b0;
        end
        // A new in-order frame may replace the one popped this cycle.
        if (rx_fire && is_inorder) begin
            out_valid_d = 1'b1;
            out_data_d  = RxData;
            exp_seq_d   = exp_seq_q + SEQW'(1);
        end
        if (ack_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (ack_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_seq_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            exp_seq_q   <= exp_seq_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // ACK storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (ack_push) begin
            ack_mem_q[wr_ptr_q[AW-1:0]] <= rx_seq;
        end
    end

    // Drive outputs from registered state.
    always_comb begin
        OutValid                   = out_valid_q;
        OutData                    = out_data_q;
        ExpectedSeq                = exp_seq_q;
        AckValid                   = ~ack_empty;
        AckData                    = '0;
        AckData[SEQOFF +: SEQW]    = ack_mem_q[rd_ptr_q[AW-1:0]];
    end

    // Resync FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Resync FSM next state: a gap starts resync, the next in-order frame ends it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (rx_fire && is_gap)     state_d = StResync;
            StResync: if (rx_fire && is_inorder) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Resync FSM output: pulse on each RUN to RESYNC transition.
    always_comb begin
        enter_resync = (state_q == StRun) & rx_fire & is_gap;
    end

`ifdef RVVI_RX_STATS_EN
    logic [31:0] dup_cnt_q, dup_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] rsy_cnt_q, rsy_cnt_d;

    // Saturating event counters.
    always_comb begin
        dup_cnt_d = dup_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rsy_cnt_d = rsy_cnt_q;
        if (rx_fire && is_dup && (dup_cnt_q != '1)) begin
            dup_cnt_d = dup_cnt_q + 32'd1;
        end
        if (rx_fire && is_gap && (gap_cnt_q != '1)) begin
            gap_cnt_d = gap_cnt_q + 32'd1;
        end
        if (enter_resync && (rsy_cnt_q != '1)) begin
            rsy_cnt_d = rsy_cnt_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dup_cnt_q <= '0;
            gap_cnt_q <= '0;
            rsy_cnt_q <= '0;
        end else begin
            dup_cnt_q <= dup_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rsy_cnt_q <= rsy_cnt_d;
        end
    end

    assign DupCount    = dup_cnt_q;
    assign GapCount    = gap_cnt_q;
    assign ResyncCount = rsy_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = enter_resync;
`endif

endmodule

// File: tb/tb_rvvi_ack_receiver.sv
// Bench for rvvi_ack_receiver: directed scenarios plus randomized traffic against a
// queue-based reference model. Uses a narrow sequence field so wrap-around is reachable.
module tb_rvvi_ack_receiver;

    localparam int unsigned W      = 48;
    localparam int unsigned ACKW   = 24;
    localparam int unsigned SEQOFF = 8;
    localparam int unsigned SEQW   = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int          SEQMOD = 1 << SEQW;

    logic            clk = 1'b0;
    logic            reset;
    logic            RxValid;
    logic [W-1:0]    RxData;
    logic            RxReady;
    logic            OutValid;
    logic [W-1:0]    OutData;
    logic            OutReady;
    logic            AckValid;
    logic [ACKW-1:0] AckData;
    logic            AckReady;
    logic [SEQW-1:0] ExpectedSeq;
`ifdef RVVI_RX_STATS_EN
    logic [31:0]     DupCount, GapCount, ResyncCount;
`endif

    rvvi_ack_receiver #(
        .WIDTH(W), .ACKWIDTH(ACKW), .SEQOFF(SEQOFF), .SEQW(SEQW), .ACKDEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .RxValid(RxValid), .RxData(RxData), .RxReady(RxReady),
        .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
        .AckValid(AckValid), .AckData(AckData), .AckReady(AckReady),
        .ExpectedSeq(ExpectedSeq)
`ifdef RVVI_RX_STATS_EN
        , .DupCount(DupCount), .GapCount(GapCount), .ResyncCount(ResyncCount)
`endif
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;

    logic [W-1:0]    exp_out_q[$], obs_out_q[$];
    logic [ACKW-1:0] exp_ack_q[$], obs_ack_q[$];
    int              obs_out_cyc[$];
    int              m_exp = 0, m_seq, m_diff;
    bit              m_resync = 0;
    int              m_dup = 0, m_gap = 0, m_rs = 0;
    logic [W-1:0]    last_frame;

    function automatic logic [W-1:0] make_frame(input int seq);
        logic [63:0] r;
        logic [W-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[W-1:0];
        f[SEQOFF +: SEQW] = SEQW'(seq);
        return f;
    endfunction

    function automatic logic [ACKW-1:0] ack_word(input int seq);
        logic [ACKW-1:0] a;
        a = '0;
        a[SEQOFF +: SEQW] = SEQW'(seq);
        return a;
    endfunction

    function automatic int fseq(input logic [W-1:0] f);
        return int'(f[SEQOFF +: SEQW]);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor and reference model: inputs are stable at the falling edge, so any
    // handshake seen here completes at the following rising edge.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            exp_out_q.delete(); obs_out_q.delete(); obs_out_cyc.delete();
            exp_ack_q.delete(); obs_ack_q.delete();
            m_exp = 0; m_resync = 0; m_dup = 0; m_gap = 0; m_rs = 0;
        end else begin
            if (OutValid && OutReady) begin
                obs_out_q.push_back(OutData);
                obs_out_cyc.push_back(cyc);
            end
            if (AckValid && AckReady) obs_ack_q.push_back(AckData);
            if (RxValid && RxReady) begin
                m_seq  = fseq(RxData);
                m_diff = (m_seq - m_exp + SEQMOD) % SEQMOD;
                if (m_diff == 0) begin
                    exp_out_q.push_back(RxData);
                    exp_ack_q.push_back(ack_word(m_seq));
                    m_exp    = (m_exp + 1) % SEQMOD;
                    m_resync = 0;
                end else if (m_diff >= SEQMOD / 2) begin
                    exp_ack_q.push_back(ack_word(m_seq));
                    m_dup++;
                end else begin
                    m_gap++;
                    if (!m_resync) begin
                        m_rs++;
                        m_resync = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; RxValid = 1'b0; OutReady = 1'b1; AckReady = 1'b1;
        tick(); tick();
        reset = 1'b1;
    endtask

    // Present one frame until accepted, bounded.
    task automatic send(input int seq);
        RxValid = 1'b1;
        RxData  = make_frame(seq);
        last_frame = RxData;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (RxReady) begin
                tick();
                RxValid = 1'b0;
                return;
            end
            tick();
        end
        total_cnt++;
        $display("FAIL send_timeout seq=%0d: RxReady stayed 0, required 1 within 50 cycles", seq);
        RxValid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; RxValid = 1'b1; RxData = make_frame(0); OutReady = 1'b1; AckReady = 1'b1;
        tick();
        total_cnt++; if (RxReady !== 1'b0) $display("FAIL reset_rxready got=%b want=0", RxReady); else pass_cnt++;
        tick();
        total_cnt++; if (OutValid !== 1'b0) $display("FAIL reset_outvalid got=%b want=0", OutValid); else pass_cnt++;
        total_cnt++; if (AckValid !== 1'b0) $display("FAIL reset_ackvalid got=%b want=0", AckValid); else pass_cnt++;
        total_cnt++; if (ExpectedSeq !== 8'd0) $display("FAIL reset_expseq got=%0d want=0", ExpectedSeq); else pass_cnt++;
`ifdef RVVI_RX_STATS_EN
        total_cnt++; if (DupCount !== 32'd0) $display("FAIL reset_dupcount got=%0d want=0", DupCount); else pass_cnt++;
`endif
        RxValid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_in_order();
        logic [W-1:0] f;
        do_reset();
        send(0); send(1); send(2);
        repeat (4) tick();
        total_cnt++; if (obs_out_q.size() != 3) $display("FAIL inorder_outcount got=%0d want=3", obs_out_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_out_q.size() && i < 3; i++) begin
            f = obs_out_q[i];
            total_cnt++; if (fseq(f) != i) $display("FAIL inorder_outseq[%0d] got=%0d want=%0d", i, fseq(f), i); else pass_cnt++;
            total_cnt++; if (obs_out_cyc[i] != obs_out_cyc[0] + i)
                $display("FAIL inorder_b2b[%0d] got cycle=%0d want=%0d", i, obs_out_cyc[i], obs_out_cyc[0] + i); else pass_cnt++;
        end
        total_cnt++; if (obs_ack_q.size() != 3) $display("FAIL inorder_ackcount got=%0d want=3", obs_ack_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_ack_q.size() && i < 3; i++) begin
            total_cnt++; if (obs_ack_q[i] !== ack_word(i)) $display("FAIL inorder_ack[%0d] got=%h want=%h", i, obs_ack_q[i], ack_word(i)); else pass_cnt++;
        end
        total_cnt++; if (ExpectedSeq !== 8'd3) $display("FAIL inorder_expseq got=%0d want=3", ExpectedSeq); else pass_cnt++;
    endtask

    task automatic test_gap();
        int seqs[6] = '{0, 2, 3, 1, 2, 3};
        logic [W-1:0] f;
        do_reset();
        foreach (seqs[i]) send(seqs[i]);
        repeat (4) tick();
        total_cnt++; if (obs_out_q.size() != 4) $display("FAIL gap_outcount got=%0d want=4", obs_out_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_out_q.size() && i < 4; i++) begin
            f = obs_out_q[i];
            total_cnt++; if (fseq(f) != i) $display("FAIL gap_outseq[%0d] got=%0d want=%0d", i, fseq(f), i); else pass_cnt++;
        end
        total_cnt++; if (obs_ack_q.size() != 4) $display("FAIL gap_ackcount got=%0d want=4", obs_ack_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_ack_q.size() && i < 4; i++) begin
            total_cnt++; if (obs_ack_q[i] !== ack_word(i)) $display("FAIL gap_ack[%0d] got=%h want=%h", i, obs_ack_q[i], ack_word(i)); else pass_cnt++;
        end
        total_cnt++; if (ExpectedSeq !== 8'd4) $display("FAIL gap_expseq got=%0d want=4", ExpectedSeq); else pass_cnt++;
`ifdef RVVI_RX_STATS_EN
        total_cnt++; if (GapCount !== 32'd2) $display("FAIL gap_gapcount got=%0d want=2", GapCount); else pass_cnt++;
        total_cnt++; if (ResyncCount !== 32'd1) $display("FAIL gap_resynccount got=%0d want=1", ResyncCount); else pass_cnt++;
        total_cnt++; if (DupCount !== 32'd0) $display("FAIL gap_dupcount got=%0d want=0", DupCount); else pass_cnt++;
`endif
    endtask

    task automatic test_dup();
        do_reset();
        send(0); send(1);
        repeat (3) tick();
        obs_out_q.delete(); obs_out_cyc.delete(); obs_ack_q.delete();
        send(0); send(1);
        repeat (3) tick();
        total_cnt++; if (obs_out_q.size() != 0) $display("FAIL dup_outcount got=%0d want=0", obs_out_q.size()); else pass_cnt++;
        total_cnt++; if (obs_ack_q.size() != 2) $display("FAIL dup_ackcount got=%0d want=2", obs_ack_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_ack_q.size() && i < 2; i++) begin
            total_cnt++; if (obs_ack_q[i] !== ack_word(i)) $display("FAIL dup_ack[%0d] got=%h want=%h", i, obs_ack_q[i], ack_word(i)); else pass_cnt++;
        end
        total_cnt++; if (ExpectedSeq !== 8'd2) $display("FAIL dup_expseq got=%0d want=2", ExpectedSeq); else pass_cnt++;
`ifdef RVVI_RX_STATS_EN
        total_cnt++; if (DupCount !== 32'd2) $display("FAIL dup_dupcount got=%0d want=2", DupCount); else pass_cnt++;
`endif
    endtask

    task automatic test_ack_backpressure();
        logic [W-1:0] f;
        do_reset();
        AckReady = 1'b0;
        for (int s = 0; s < 4; s++) send(s);
        RxValid = 1'b1; RxData = make_frame(4);
        repeat (2) begin
            @(negedge clk);
            total_cnt++; if (RxReady !== 1'b0) $display("FAIL ackbp_full_rxready got=%b want=0", RxReady); else pass_cnt++;
            tick();
        end
        AckReady = 1'b1;
        @(negedge clk);
        total_cnt++; if (RxReady !== 1'b0) $display("FAIL ackbp_pop_cycle_rxready got=%b want=0", RxReady); else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++; if (RxReady !== 1'b1) $display("FAIL ackbp_after_pop_rxready got=%b want=1", RxReady); else pass_cnt++;
        tick();
        RxValid = 1'b0;
        repeat (6) tick();
        total_cnt++; if (obs_out_q.size() != 5) $display("FAIL ackbp_outcount got=%0d want=5", obs_out_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_out_q.size() && i < 5; i++) begin
            f = obs_out_q[i];
            total_cnt++; if (fseq(f) != i) $display("FAIL ackbp_outseq[%0d] got=%0d want=%0d", i, fseq(f), i); else pass_cnt++;
        end
        total_cnt++; if (obs_ack_q.size() != 5) $display("FAIL ackbp_ackcount got=%0d want=5", obs_ack_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_ack_q.size() && i < 5; i++) begin
            total_cnt++; if (obs_ack_q[i] !== ack_word(i)) $display("FAIL ackbp_ack[%0d] got=%h want=%h", i, obs_ack_q[i], ack_word(i)); else pass_cnt++;
        end
    endtask

    task automatic test_out_backpressure();
        logic [W-1:0] f0, f1;
        do_reset();
        OutReady = 1'b0;
        send(0);
        f0 = last_frame;
        f1 = make_frame(1);
        RxValid = 1'b1; RxData = f1;
        repeat (3) begin
            @(negedge clk);
            total_cnt++; if (RxReady !== 1'b0) $display("FAIL outbp_rxready got=%b want=0", RxReady); else pass_cnt++;
            total_cnt++; if (OutValid !== 1'b1) $display("FAIL outbp_outvalid got=%b want=1", OutValid); else pass_cnt++;
            total_cnt++; if (OutData !== f0) $display("FAIL outbp_held got=%h want=%h", OutData, f0); else pass_cnt++;
            tick();
        end
        OutReady = 1'b1;
        @(negedge clk);
        total_cnt++; if (RxReady !== 1'b1) $display("FAIL outbp_release_rxready got=%b want=1", RxReady); else pass_cnt++;
        tick();
        RxValid = 1'b0;
        total_cnt++; if (OutValid !== 1'b1) $display("FAIL outbp_next_valid got=%b want=1", OutValid); else pass_cnt++;
        total_cnt++; if (OutData !== f1) $display("FAIL outbp_next_data got=%h want=%h", OutData, f1); else pass_cnt++;
        repeat (2) tick();
    endtask

    task automatic test_wrap_and_reset();
        logic [W-1:0] f;
        do_reset();
        for (int s = 0; s < SEQMOD - 1; s++) send(s);
        repeat (2) tick();
        total_cnt++; if (ExpectedSeq !== 8'hFF) $display("FAIL wrap_pre_expseq got=%0d want=255", ExpectedSeq); else pass_cnt++;
        obs_out_q.delete(); obs_out_cyc.delete(); obs_ack_q.delete();
        send(SEQMOD - 1); send(0);
        repeat (3) tick();
        total_cnt++; if (obs_out_q.size() != 2) $display("FAIL wrap_outcount got=%0d want=2", obs_out_q.size()); else pass_cnt++;
        if (obs_out_q.size() == 2) begin
            f = obs_out_q[0];
            total_cnt++; if (fseq(f) != SEQMOD - 1) $display("FAIL wrap_out0 got=%0d want=255", fseq(f)); else pass_cnt++;
            f = obs_out_q[1];
            total_cnt++; if (fseq(f) != 0) $display("FAIL wrap_out1 got=%0d want=0", fseq(f)); else pass_cnt++;
        end
        total_cnt++; if (ExpectedSeq !== 8'd1) $display("FAIL wrap_expseq got=%0d want=1", ExpectedSeq); else pass_cnt++;
        OutReady = 1'b0; AckReady = 1'b0;
        send(1);
        total_cnt++; if (OutValid !== 1'b1 || AckValid !== 1'b1)
            $display("FAIL midrst_pre got=%b%b want=11", OutValid, AckValid); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++; if (OutValid !== 1'b0) $display("FAIL midrst_outvalid got=%b want=0", OutValid); else pass_cnt++;
        total_cnt++; if (AckValid !== 1'b0) $display("FAIL midrst_ackvalid got=%b want=0", AckValid); else pass_cnt++;
        total_cnt++; if (ExpectedSeq !== 8'd0) $display("FAIL midrst_expseq got=%0d want=0", ExpectedSeq); else pass_cnt++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int off, pend_out, pend_ack;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            off      = int'($urandom_range(6, 0)) - 3;
            RxValid  = ($urandom() % 10) < 7;
            RxData   = make_frame((m_exp + off + SEQMOD) % SEQMOD);
            OutReady = ($urandom() % 10) < 7;
            AckReady = ($urandom() % 4) != 0;
            #1;
            pend_out = exp_out_q.size() - obs_out_q.size();
            pend_ack = exp_ack_q.size() - obs_ack_q.size();
            total_cnt++; if (OutValid !== (pend_out > 0)) $display("FAIL rnd_outvalid n=%0d got=%b want=%b", n, OutValid, pend_out > 0); else pass_cnt++;
            total_cnt++; if (AckValid !== (pend_ack > 0)) $display("FAIL rnd_ackvalid n=%0d got=%b want=%b", n, AckValid, pend_ack > 0); else pass_cnt++;
            total_cnt++; if (RxReady !== (pend_ack < DEPTH && (pend_out == 0 || OutReady)))
                $display("FAIL rnd_rxready n=%0d got=%b want=%b", n, RxReady, pend_ack < DEPTH && (pend_out == 0 || OutReady)); else pass_cnt++;
            total_cnt++; if (ExpectedSeq !== SEQW'(m_exp)) $display("FAIL rnd_expseq n=%0d got=%0d want=%0d", n, ExpectedSeq, m_exp); else pass_cnt++;
            tick();
        end
        RxValid = 1'b0; OutReady = 1'b1; AckReady = 1'b1;
        repeat (8) tick();
        total_cnt++; if (obs_out_q.size() != exp_out_q.size()) $display("FAIL rnd_outcount got=%0d want=%0d", obs_out_q.size(), exp_out_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_out_q.size() && i < exp_out_q.size(); i++) begin
            total_cnt++; if (obs_out_q[i] !== exp_out_q[i]) $display("FAIL rnd_out[%0d] got=%h want=%h", i, obs_out_q[i], exp_out_q[i]); else pass_cnt++;
        end
        total_cnt++; if (obs_ack_q.size() != exp_ack_q.size()) $display("FAIL rnd_ackcount got=%0d want=%0d", obs_ack_q.size(), exp_ack_q.size()); else pass_cnt++;
        for (int i = 0; i < obs_ack_q.size() && i < exp_ack_q.size(); i++) begin
            total_cnt++; if (obs_ack_q[i] !== exp_ack_q[i]) $display("FAIL rnd_ack[%0d] got=%h want=%h", i, obs_ack_q[i], exp_ack_q[i]); else pass_cnt++;
        end
`ifdef RVVI_RX_STATS_EN
        total_cnt++; if (DupCount !== 32'(m_dup)) $display("FAIL rnd_dupcount got=%0d want=%0d", DupCount, m_dup); else pass_cnt++;
        total_cnt++; if (GapCount !== 32'(m_gap)) $display("FAIL rnd_gapcount got=%0d want=%0d", GapCount, m_gap); else pass_cnt++;
        total_cnt++; if (ResyncCount !== 32'(m_rs)) $display("FAIL rnd_resynccount got=%0d want=%0d", ResyncCount, m_rs); else pass_cnt++;
`endif
    endtask

    initial begin
        reset = 1'b0; RxValid = 1'b0; RxData = '0; OutReady = 1'b1; AckReady = 1'b1;
        last_frame = '0;
        #1;
        test_reset();
        test_in_order();
        test_gap();
        test_dup();
        test_ack_backpressure();
        test_out_backpressure();
        test_wrap_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
